// File: rtl/la_pkg.sv
// Shared logic-analyzer types and constants used by the dump path.
package la_pkg;

    localparam int ENTRIES_DEFAULT = 384;

    localparam logic [2:0] CH1 = 3'd1;
    localparam logic [2:0] CH2 = 3'd2;
    localparam logic [2:0] CH3 = 3'd3;
    localparam logic [2:0] CH4 = 3'd4;
    localparam logic [2:0] CH5 = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        TX    = 3'd3,
        DONE  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/dump_addr_ctr.sv
// Circular-buffer read address plus sent-byte count. The address wraps at
// ENTRIES-1; an out-of-range start address still wraps naturally at 2**AW-1.
module dump_addr_ctr #(
    parameter int ENTRIES = 384,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // Load restarts the walk at the oldest sample; inc steps address and count together.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = load_addr;
            cnt_d  = '0;
        end else if (inc) begin
            cnt_d  = cnt_q + AW'(1);
            addr_d = (addr_q == LAST_IDX) ? '0 : addr_q + AW'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/dump_ctrl.sv
// Streams one channel's circular sample buffer, oldest to newest, to the UART TX.
module dump_ctrl
    import la_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dump_en,
    input  logic [2:0]    dump_chan,
    input  logic [AW-1:0] start_addr,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    rdataCH1,
    input  logic [7:0]    rdataCH2,
    input  logic [7:0]    rdataCH3,
    input  logic [7:0]    rdataCH4,
    input  logic [7:0]    rdataCH5,
    output logic [7:0]    tx_data,
    output logic          trmt,
    input  logic          tx_done,
    output logic          busy,
    output logic          dump_done
);

    dump_state_e state_q, state_d;
    logic [2:0]  chan_q, chan_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        trmt_q, trmt_d;
    logic        dump_done_q, dump_done_d;
    logic        ctr_load, ctr_inc, ctr_last;
    logic        chan_ok;
    logic [7:0]  ch_byte;

    assign chan_ok = (dump_chan >= CH1) && (dump_chan <= CH5);

    dump_addr_ctr #(.ENTRIES(ENTRIES), .AW(AW)) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .load_addr (start_addr),
        .inc       (ctr_inc),
        .addr      (ram_addr),
        .last      (ctr_last)
    );

    // Select the latched channel's RAM read data.
    always_comb begin
        ch_byte = '0;
        case (chan_q)
            CH1:     ch_byte = rdataCH1;
            CH2:     ch_byte = rdataCH2;
            CH3:     ch_byte = rdataCH3;
            CH4:     ch_byte = rdataCH4;
            CH5:     ch_byte = rdataCH5;
            default: ch_byte = '0;
        endcase
    end

    // Next-state and registered-output logic. tx_done during the trmt cycle is dropped.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        ctr_load    = 1'b0;
        ctr_inc     = 1'b0;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        dump_done_d = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (dump_en) begin
                    if (chan_ok) begin
                        chan_d   = dump_chan;
                        ctr_load = 1'b1;
                        state_d  = READ;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            READ:  state_d = LATCH;
            LATCH: begin
                tx_data_d = ch_byte;
                trmt_d    = 1'b1;
                state_d   = TX;
            end
            TX: begin
                if (tx_done && !trmt_q) begin
                    if (ctr_last) begin
                        state_d = DONE;
                    end else begin
                        ctr_inc = 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            dump_done_q <= dump_done_d;
        end
    end

    assign ram_rd_en = (state_q == READ);
    assign busy      = (state_q == READ) || (state_q == LATCH) || (state_q == TX);
    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign dump_done = dump_done_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// Self-checking bench for dump_ctrl with ENTRIES=8, AW=3.
module tb_dump_ctrl;

    localparam int ENT = 8;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dump_en = 1'b0;
    logic [2:0]    dump_chan = '0;
    logic [AW-1:0] start_addr = '0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [7:0]    rd1 = '0, rd2 = '0, rd3 = '0, rd4 = '0, rd5 = '0;
    logic [7:0]    tx_data;
    logic          trmt;
    logic          tx_done = 1'b0;
    logic          busy;
    logic          dump_done;

    int checks = 0;
    int errors = 0;

    dump_ctrl #(.ENTRIES(ENT), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .dump_en(dump_en), .dump_chan(dump_chan),
        .start_addr(start_addr), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .rdataCH1(rd1), .rdataCH2(rd2), .rdataCH3(rd3), .rdataCH4(rd4), .rdataCH5(rd5),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done), .busy(busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    // RAM model: byte is {chan nibble, addr nibble}, one cycle after read strobe.
    always @(posedge clk) begin
        if (ram_rd_en) begin
            rd1 <= {4'd1, 1'b0, ram_addr};
            rd2 <= {4'd2, 1'b0, ram_addr};
            rd3 <= {4'd3, 1'b0, ram_addr};
            rd4 <= {4'd4, 1'b0, ram_addr};
            rd5 <= {4'd5, 1'b0, ram_addr};
        end
    end

    // UART model: tx_done pulse uart_dly cycles after trmt.
    int uart_dly = 5;
    int tdly = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done <= 1'b0;
            tdly    <= 0;
        end else begin
            tx_done <= 1'b0;
            if (trmt) begin
                if (uart_dly == 1) tx_done <= 1'b1;
                else               tdly <= uart_dly - 1;
            end else if (tdly != 0) begin
                tdly <= tdly - 1;
                if (tdly == 1) tx_done <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard and event monitor.
    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    int rd_cnt = 0, trmt_cnt = 0, done_cnt = 0, txd_cnt = 0;
    bit busy_seen = 0;
    logic trmt_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rd_en) rd_cnt++;
            if (dump_done) done_cnt++;
            if (tx_done)   txd_cnt++;
            if (busy)      busy_seen = 1;
            if (trmt && trmt_prev) begin
                checks++; errors++;
                $display("FAIL trmt_double: trmt high two cycles, expected one");
            end
            if (trmt) begin
                trmt_cnt++;
                sent_q.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_trmt: tx_data 0x%0h, expected none", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
        trmt_prev = trmt;
    end

    function automatic logic [7:0] exp_byte(input logic [2:0] ch, input int st, input int k);
        int a;
        a = (st + k) % ENT;
        return {1'b0, ch, 4'(a)};
    endfunction

    // Run one dump; optionally pulse a competing dump_en at cycle mid_at.
    task automatic run_dump(input logic [2:0] ch, input int st, input bit valid,
                            input logic [7:0] first, input int mid_at, input string tag);
        int rd0, tr0, dn0, lat;
        bit got;
        rd0 = rd_cnt; tr0 = trmt_cnt; dn0 = done_cnt;
        busy_seen = 0;
        sent_q.delete();
        if (valid) for (int k = 0; k < ENT; k++) exp_q.push_back(exp_byte(ch, st, k));
        @(negedge clk);
        dump_en = 1'b1; dump_chan = ch; start_addr = AW'(st);
        lat = 0; got = 0;
        while (lat < 1000 && !got) begin
            @(negedge clk);
            lat++;
            dump_en = 1'b0;
            if (mid_at != 0 && lat == mid_at) begin
                dump_en = 1'b1; dump_chan = 3'd5; start_addr = 3'd3;
            end
            if (dump_done) got = 1;
        end
        dump_en = 1'b0;
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt - dn0, 1);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        if (valid) begin
            check({tag, "_rd_cnt"}, rd_cnt - rd0, ENT);
            check({tag, "_trmt_cnt"}, trmt_cnt - tr0, ENT);
            if (sent_q.size() > 0) check({tag, "_first"}, {24'd0, sent_q[0]}, {24'd0, first});
        end else begin
            check({tag, "_done_lat"}, lat, 2);
            check({tag, "_rd_cnt"}, rd_cnt - rd0, 0);
            check({tag, "_trmt_cnt"}, trmt_cnt - tr0, 0);
            check({tag, "_busy_seen"}, {31'd0, busy_seen}, 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0] chan;
        int         start;
        bit         valid;
        logic [7:0] first;
        string      tag;
    } vec_t;
    vec_t vecs[6];

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, {31'd0, ram_rd_en}, 32'd0);
        check({tag, "_trmt"}, {31'd0, trmt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, dump_done}, 32'd0);
        check({tag, "_addr"}, {29'd0, ram_addr}, 32'd0);
        check({tag, "_txdata"}, {24'd0, tx_data}, 32'd0);
    endtask

    initial begin
        int t0, dn0;
        bit ok;
        vecs[0] = '{3'd3, 0, 1'b1, 8'h30, "ch3_s0"};
        vecs[1] = '{3'd1, 5, 1'b1, 8'h15, "ch1_s5"};
        vecs[2] = '{3'd0, 0, 1'b0, 8'h00, "ch0_bad"};
        vecs[3] = '{3'd6, 3, 1'b0, 8'h00, "ch6_bad"};
        vecs[4] = '{3'd7, 1, 1'b0, 8'h00, "ch7_bad"};
        vecs[5] = '{3'd5, 7, 1'b1, 8'h57, "ch5_s7"};

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven dumps.
        for (int i = 0; i < 6; i++)
            run_dump(vecs[i].chan, vecs[i].start, vecs[i].valid, vecs[i].first, 0, vecs[i].tag);

        // Competing dump_en mid-dump must be ignored.
        run_dump(3'd2, 0, 1'b1, 8'h20, 6, "mid_en");

        // Reset after the third tx_done aborts silently.
        for (int k = 0; k < ENT; k++) exp_q.push_back(exp_byte(3'd2, 0, k));
        t0 = txd_cnt;
        @(negedge clk);
        dump_en = 1'b1; dump_chan = 3'd2; start_addr = '0;
        @(negedge clk);
        dump_en = 1'b0;
        ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (txd_cnt - t0 >= 3) ok = 1;
        end
        check("abort_reach_3", {31'd0, ok}, 32'd1);
        dn0 = done_cnt;
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - dn0, 0);
        run_dump(3'd4, 2, 1'b1, 8'h42, 0, "post_rst");

        // Latency with a one-cycle UART.
        uart_dly = 1;
        for (int k = 0; k < ENT; k++) exp_q.push_back(exp_byte(3'd3, 0, k));
        dn0 = done_cnt;
        @(negedge clk);
        dump_en = 1'b1; dump_chan = 3'd3; start_addr = '0;
        @(negedge clk);
        dump_en = 1'b0;
        check("lat_en_to_rd", {31'd0, ram_rd_en}, 32'd1);
        @(negedge clk);
        check("lat_latch_rd", {31'd0, ram_rd_en}, 32'd0);
        check("lat_latch_trmt", {31'd0, trmt}, 32'd0);
        @(negedge clk);
        check("lat_rd_to_trmt", {31'd0, trmt}, 32'd1);
        @(negedge clk);
        check("lat_txdone_seen", {31'd0, tx_done}, 32'd1);
        @(negedge clk);
        check("lat_txdone_to_rd", {31'd0, ram_rd_en}, 32'd1);
        ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (dump_done) ok = 1;
        end
        check("lat_done_seen", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        check("lat_queue_left", exp_q.size(), 0);
        check("lat_done_cnt", done_cnt - dn0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dump_ctrl.md
Name: dump_ctrl

Overview:
- Read-side counterpart of the channel sampling/capture path. After a capture completes, it reads one channel's circular sample buffer from the oldest sample to the newest.
- Each 8-bit sample is handed to the UART transmitter with a trmt/tx_done handshake.
- Sits between the five per-channel sample RAMs and the UART TX in the logic-analyzer top level; started by the command processor.

Parameters:
ENTRIES, 384, number of samples per channel buffer (depth of each circular RAM)
AW, 9, RAM address width; must satisfy 2**AW >= ENTRIES

Ports:
clk  input  1  system clock (same clk as the sampler and capture logic)
rst_n  input  1  asynchronous active-low reset
dump_en  input  1  one-cycle start pulse from the command processor
dump_chan  input  3  channel to dump; 1..5 valid; 0, 6 and 7 invalid
start_addr  input  AW  address of the oldest sample (capture write pointer at capture end)
ram_rd_en  output  1  read strobe to all channel RAMs
ram_addr  output  AW  read address to all channel RAMs
rdataCH1..rdataCH5  input  8 each  synchronous RAM read data; valid the cycle after ram_rd_en
tx_data  output  8  byte to the UART TX
trmt  output  1  one-cycle transmit request to the UART TX
tx_done  input  1  UART byte-complete pulse
busy  output  1  high from acceptance of dump_en until dump_done
dump_done  output  1  one-cycle pulse when the dump completes or is rejected

Behaviour:
- Reset (async, rst_n low): state=IDLE. ram_rd_en, trmt, busy and dump_done are 0; ram_addr=0; tx_data=0; internal count=0. Reset asserted mid-dump aborts immediately. No dump_done is issued for an aborted dump.
- Outputs are registered, except ram_rd_en and busy, which decode the state.
- States: IDLE, READ, LATCH, TX, DONE.
- IDLE:
  - dump_en with dump_chan in 1..5: latch the channel, ram_addr<=start_addr, cnt<=0, go to READ.
  - dump_en with an invalid channel: go to DONE. No RAM read and no trmt.
  - No dump_en: stay in IDLE.
- READ: ram_rd_en=1 for exactly one cycle; go to LATCH.
- LATCH:
  - tx_data<=rdataCHn for the latched channel.
  - trmt<=1, giving a one-cycle pulse visible in the first TX cycle.
  - Go to TX.
- TX: wait for tx_done. tx_done is sampled only in this state and ignored elsewhere.
  - On tx_done with cnt==ENTRIES-1: go to DONE.
  - On tx_done otherwise: cnt<=cnt+1; ram_addr<=(ram_addr==ENTRIES-1) ? 0 : ram_addr+1; go to READ.
- DONE: dump_done=1 for one cycle; go to IDLE.
- busy = (state != IDLE) and (state != DONE)... more precisely busy is high in READ, LATCH and TX.
- dump_en is ignored while not in IDLE. The latched channel and start address cannot change mid-dump.
- Address wrap:
  - The address wraps at ENTRIES-1 to 0, not at 2**AW.
  - start_addr >= ENTRIES is out of contract; the implementation must still wrap to 0 after reaching 2**AW-1 with no hang.
- Exactly ENTRIES bytes are sent per valid dump. Byte k is the RAM contents at (start_addr+k) mod ENTRIES.
- Latency:
  - dump_en to first ram_rd_en: 1 cycle.
  - ram_rd_en to trmt: 2 cycles.
  - tx_done to next ram_rd_en: 1 cycle.
- tx_done arriving in the same cycle as trmt cannot occur with the team UART; if it does, it is ignored.
- cnt width: AW bits; compare is against ENTRIES-1.

Decomposition:
- Shared package (la_pkg):
  - State enum typedef for dump_ctrl.
  - Constant ENTRIES_DEFAULT=384.
  - Channel-select constants CH1..CH5=3'd1..3'd5.
- One natural sub-module: dump_addr_ctr, the wrap-at-ENTRIES address/count counter with load, inc and last flag. Everything else is inline.
- The channel mux is inline combinational logic.

Test Plan (bench overrides ENTRIES=8, AW=3; RAM model returns byte {chan,addr}; UART model returns tx_done 5 cycles after trmt):
1. dump_en, dump_chan=3, start_addr=0 -> 8 trmt pulses with tx_data 0x30..0x37, then one dump_done pulse; busy low afterwards.
2. dump_chan=1, start_addr=5 -> tx_data sequence 0x15,0x16,0x17,0x10,0x11,0x12,0x13,0x14 (wrap at 7->0); exactly 8 bytes.
3. dump_chan=0, then a separate test with dump_chan=6 -> dump_done 2 cycles after dump_en; zero ram_rd_en and zero trmt pulses; busy never high.
4. Second dump_en (chan=5) pulsed mid-dump of chan=2 -> ignored; all 8 bytes are chan-2 data; exactly one dump_done.
5. rst_n pulsed low after the 3rd tx_done -> all outputs 0 asynchronously; no dump_done. A fresh dump_en (chan=4, start_addr=2) then completes 8 bytes starting at 0x42.
6. Timing check with tx_done delay 1 cycle -> dump_en-to-ram_rd_en =1, ram_rd_en-to-trmt =2, tx_done-to-ram_rd_en =1; trmt is never high for 2 consecutive cycles.
